// File: rtl/vector_pkg.sv
// Shared definitions for the vector issue path.
// Provides the command opcode encoding, its width, and a helper that tells
// whether an opcode is executed by the lanes (elementwise ops) or not.
package vector_pkg;

  localparam int unsigned OpW = 3;

  // Codes 5-7 are illegal and complete without touching the register file.
  typedef enum logic [OpW-1:0] {
    OpVadd  = 3'd0,
    OpVsub  = 3'd1,
    OpVmul  = 3'd2,
    OpVsadd = 3'd3,
    OpVread = 3'd4
  } vec_op_e;

  // True for opcodes that stream beats through the lanes with write-back.
  function automatic logic op_is_lane(logic [OpW-1:0] op);
    return op <= OpVsadd;
  endfunction

endpackage

// File: rtl/vector_beat_counter.sv
// Beat counter for the vector issue controller.
// Ports:
//   clk_i, reset_i : clock, asynchronous active-high reset
//   clr_i          : force the count to zero (dominates inc_i)
//   inc_i          : advance one beat, wrapping after the last beat
//   beat_o         : current beat index
//   last_o         : current beat is the final beat of a vector
module vector_beat_counter #(
  parameter int unsigned beats_p = 4,
  localparam int unsigned beat_w = $clog2(beats_p)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [beat_w-1:0] beat_o,
  output logic              last_o
);

  logic [beat_w-1:0] beat_q, beat_d;

  assign last_o = (beat_q == beat_w'(beats_p - 1));
  assign beat_o = beat_q;

  always_comb begin
    beat_d = beat_q;
    if (clr_i) begin
      beat_d = '0;
    end else if (inc_i) begin
      // Explicit wrap so non-power-of-two beat counts behave.
      beat_d = last_o ? '0 : beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

endmodule

// File: rtl/vector_issue_ctrl.sv
// Vector issue controller.
// Accepts one command at a time, then either streams every beat of source
// vectors A/B to the lanes with one-cycle-delayed write-back to C, or reads
// vector A out beat by beat through a valid/yumi handshake.
// Ports:
//   clk_i, reset_i                     : clock, asynchronous active-high reset
//   v_i/ready_o, op_i, addr*_i, scalar_i : command handshake and operands
//   rf_rd_*                            : register-file read strobe/address/beat/data
//   lane_op_o, lane_scalar_o           : latched opcode and scalar for the lanes
//   rf_wr_*                            : register-file write strobe/address/beat
//   done_o                             : one-cycle completion pulse
//   r_data_o/v_o/yumi_i                : read-out data stream
module vector_issue_ctrl
  import vector_pkg::*;
#(
  parameter int unsigned els_p   = 32,
  parameter int unsigned vlen_p  = 8,
  parameter int unsigned vdw_p   = 8,
  parameter int unsigned lanes_p = 2,
  localparam int unsigned addr_w = $clog2(els_p),
  localparam int unsigned beats  = vlen_p / lanes_p,
  localparam int unsigned beat_w = $clog2(beats),
  localparam int unsigned data_w = lanes_p * vdw_p
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              v_i,
  output logic              ready_o,
  input  logic [OpW-1:0]    op_i,
  input  logic [addr_w-1:0] addrA_i,
  input  logic [addr_w-1:0] addrB_i,
  input  logic [addr_w-1:0] addrC_i,
  input  logic [vdw_p-1:0]  scalar_i,
  output logic              rf_rd_v_o,
  output logic [addr_w-1:0] rf_rd_addrA_o,
  output logic [addr_w-1:0] rf_rd_addrB_o,
  output logic [beat_w-1:0] rf_rd_beat_o,
  input  logic [data_w-1:0] rf_rd_data_i,
  output logic [OpW-1:0]    lane_op_o,
  output logic [vdw_p-1:0]  lane_scalar_o,
  output logic              rf_wr_v_o,
  output logic [addr_w-1:0] rf_wr_addr_o,
  output logic [beat_w-1:0] rf_wr_beat_o,
  output logic              done_o,
  output logic [data_w-1:0] r_data_o,
  output logic              v_o,
  input  logic              yumi_i
);

  typedef enum logic [2:0] {
    StIdle, StExec, StWbLast, StRdReq, StRdCap, StRdOut, StDone
  } state_e;

  state_e              state_q;
  logic                ready_q, rd_v_q, wr_v_q, done_q, v_q;
  logic [OpW-1:0]      op_q;
  logic [vdw_p-1:0]    scalar_q;
  logic [addr_w-1:0]   addr_a_q, addr_b_q, addr_c_q;
  logic [beat_w-1:0]   wr_beat_q;
  logic [data_w-1:0]   r_data_q;

  logic                cnt_clr, cnt_inc, beat_last;
  logic [beat_w-1:0]   beat;

  always_comb begin
    cnt_inc = (state_q == StExec) || ((state_q == StRdOut) && yumi_i);
    cnt_clr = (state_q == StWbLast) || ((state_q == StRdOut) && yumi_i && beat_last);
  end

  vector_beat_counter #(
    .beats_p (beats)
  ) u_beat_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (cnt_clr),
    .inc_i   (cnt_inc),
    .beat_o  (beat),
    .last_o  (beat_last)
  );

  // Strobes are registered on the transition into the state that owns them,
  // so they never depend combinationally on inputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      ready_q   <= 1'b1;
      rd_v_q    <= 1'b0;
      wr_v_q    <= 1'b0;
      done_q    <= 1'b0;
      v_q       <= 1'b0;
      op_q      <= '0;
      scalar_q  <= '0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      addr_c_q  <= '0;
      wr_beat_q <= '0;
      r_data_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (v_i) begin
            op_q     <= op_i;
            scalar_q <= scalar_i;
            addr_a_q <= addrA_i;
            addr_b_q <= addrB_i;
            addr_c_q <= addrC_i;
            ready_q  <= 1'b0;
            if (op_is_lane(op_i)) begin
              state_q <= StExec;
              rd_v_q  <= 1'b1;
            end else if (op_i == OpVread) begin
              state_q <= StRdReq;
              rd_v_q  <= 1'b1;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StExec: begin
          // Write-back trails the read by one cycle, so C may alias A or B.
          wr_v_q    <= 1'b1;
          wr_beat_q <= beat;
          if (beat_last) begin
            state_q <= StWbLast;
            rd_v_q  <= 1'b0;
          end
        end
        StWbLast: begin
          wr_v_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StRdReq: begin
          rd_v_q  <= 1'b0;
          state_q <= StRdCap;
        end
        StRdCap: begin
          r_data_q <= rf_rd_data_i;
          v_q      <= 1'b1;
          state_q  <= StRdOut;
        end
        StRdOut: begin
          if (yumi_i) begin
            v_q <= 1'b0;
            if (beat_last) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              rd_v_q  <= 1'b1;
              state_q <= StRdReq;
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          rd_v_q  <= 1'b0;
          wr_v_q  <= 1'b0;
          done_q  <= 1'b0;
          v_q     <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o       = ready_q;
  assign rf_rd_v_o     = rd_v_q;
  assign rf_rd_addrA_o = addr_a_q;
  assign rf_rd_addrB_o = addr_b_q;
  assign rf_rd_beat_o  = beat;
  assign lane_op_o     = op_q;
  assign lane_scalar_o = scalar_q;
  assign rf_wr_v_o     = wr_v_q;
  assign rf_wr_addr_o  = addr_c_q;
  assign rf_wr_beat_o  = wr_beat_q;
  assign done_o        = done_q;
  assign r_data_o      = r_data_q;
  assign v_o           = v_q;

endmodule

// File: tb/tb_vector_issue_ctrl.sv
// Self-checking bench for vector_issue_ctrl. Expected behaviour comes from a
// cycle-timeline model of each command kind plus an element-level register
// file image used to predict read-out data.
module tb_vector_issue_ctrl;

  localparam int ELS   = 32;
  localparam int VLEN  = 8;
  localparam int VDW   = 8;
  localparam int LANES = 2;
  localparam int BEATS = VLEN / LANES;
  localparam int AW    = $clog2(ELS);
  localparam int BW    = $clog2(BEATS);
  localparam int DW    = LANES * VDW;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          v_i;
  logic          ready_o;
  logic [2:0]    op_i;
  logic [AW-1:0] addrA_i, addrB_i, addrC_i;
  logic [VDW-1:0] scalar_i;
  logic          rf_rd_v_o;
  logic [AW-1:0] rf_rd_addrA_o, rf_rd_addrB_o;
  logic [BW-1:0] rf_rd_beat_o;
  logic [DW-1:0] rf_rd_data_i;
  logic [2:0]    lane_op_o;
  logic [VDW-1:0] lane_scalar_o;
  logic          rf_wr_v_o;
  logic [AW-1:0] rf_wr_addr_o;
  logic [BW-1:0] rf_wr_beat_o;
  logic          done_o;
  logic [DW-1:0] r_data_o;
  logic          v_o;
  logic          yumi_i;

  vector_issue_ctrl dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .v_i           (v_i),
    .ready_o       (ready_o),
    .op_i          (op_i),
    .addrA_i       (addrA_i),
    .addrB_i       (addrB_i),
    .addrC_i       (addrC_i),
    .scalar_i      (scalar_i),
    .rf_rd_v_o     (rf_rd_v_o),
    .rf_rd_addrA_o (rf_rd_addrA_o),
    .rf_rd_addrB_o (rf_rd_addrB_o),
    .rf_rd_beat_o  (rf_rd_beat_o),
    .rf_rd_data_i  (rf_rd_data_i),
    .lane_op_o     (lane_op_o),
    .lane_scalar_o (lane_scalar_o),
    .rf_wr_v_o     (rf_wr_v_o),
    .rf_wr_addr_o  (rf_wr_addr_o),
    .rf_wr_beat_o  (rf_wr_beat_o),
    .done_o        (done_o),
    .r_data_o      (r_data_o),
    .v_o           (v_o),
    .yumi_i        (yumi_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  bit hold6_g = 1'b0;

  // Register-file image, one entry per element.
  logic [VDW-1:0] elem [ELS][VLEN];

  logic          prev_rd_v;
  logic [AW-1:0] prev_a;
  logic [BW-1:0] prev_b;

  function automatic logic [DW-1:0] beat_word(int a, int b);
    logic [DW-1:0] w;
    for (int l = 0; l < LANES; l++) w[l*VDW +: VDW] = elem[a][b*LANES + l];
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; read data appears only in the cycle after a strobe,
  // otherwise the data bus carries junk.
  task automatic tick();
    prev_rd_v = rf_rd_v_o;
    prev_a    = rf_rd_addrA_o;
    prev_b    = rf_rd_beat_o;
    @(posedge clk_i);
    #1;
    rf_rd_data_i = (prev_rd_v === 1'b1) ? beat_word(int'(prev_a), int'(prev_b))
                                        : DW'($urandom);
  endtask

  task automatic issue(input logic [2:0] op, input int a, input int b, input int c,
                       input logic [VDW-1:0] s);
    int guard = 0;
    while (ready_o !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    chk("ready_before_issue", ready_o, 1);
    v_i = 1'b1; op_i = op; scalar_i = s;
    addrA_i = AW'(a); addrB_i = AW'(b); addrC_i = AW'(c);
    tick();
    if (hold6_g) begin
      v_i = 1'b1; op_i = 3'd6;
    end else begin
      v_i = 1'($urandom_range(0, 1)); op_i = 3'($urandom);
    end
    addrA_i = AW'($urandom); addrB_i = AW'($urandom); addrC_i = AW'($urandom);
    scalar_i = VDW'($urandom);
  endtask

  // Lane op: reads in cycles 1..B, writes in 2..B+1, done in B+2, ready in B+3.
  task automatic check_exec(input logic [2:0] op, input int a, input int b, input int c,
                            input logic [VDW-1:0] s);
    int wcnt [BEATS];
    bit exp_rd, exp_wr;
    for (int i = 0; i < BEATS; i++) wcnt[i] = 0;
    for (int k = 1; k <= BEATS + 2; k++) begin
      exp_rd = (k <= BEATS);
      exp_wr = (k >= 2) && (k <= BEATS + 1);
      chk("exec_rd_v", rf_rd_v_o, exp_rd);
      if (exp_rd) begin
        chk("exec_rd_beat", rf_rd_beat_o, k - 1);
        chk("exec_rd_addrA", rf_rd_addrA_o, a);
        chk("exec_rd_addrB", rf_rd_addrB_o, b);
      end
      chk("exec_wr_v", rf_wr_v_o, exp_wr);
      if (exp_wr) begin
        chk("exec_wr_addr", rf_wr_addr_o, c);
        chk("exec_wr_beat", rf_wr_beat_o, k - 2);
      end
      chk("exec_done", done_o, k == BEATS + 2);
      chk("exec_ready", ready_o, 0);
      chk("exec_lane_op", lane_op_o, op);
      chk("exec_lane_scalar", lane_scalar_o, s);
      if (rf_wr_v_o === 1'b1) wcnt[rf_wr_beat_o]++;
      tick();
    end
    chk("exec_end_ready", ready_o, 1);
    chk("exec_end_done", done_o, 0);
    chk("exec_end_rd_v", rf_rd_v_o, 0);
    chk("exec_end_wr_v", rf_wr_v_o, 0);
    for (int i = 0; i < BEATS; i++) chk("exec_writes_per_beat", wcnt[i], 1);
    v_i = hold6_g;
  endtask

  // d1 >= 0 fixes the stall on beat 1; other beats stall a random 0-3 cycles.
  task automatic check_read(input int a, input int d1);
    int d;
    logic [DW-1:0] exp_w;
    for (int b = 0; b < BEATS; b++) begin
      d = (b == 1 && d1 >= 0) ? d1 : int'($urandom_range(0, 3));
      chk("rd_req_v", rf_rd_v_o, 1);
      chk("rd_req_addrA", rf_rd_addrA_o, a);
      chk("rd_req_beat", rf_rd_beat_o, b);
      chk("rd_req_vo", v_o, 0);
      yumi_i = 1'($urandom_range(0, 1));
      tick();
      chk("rd_cap_rd_v", rf_rd_v_o, 0);
      chk("rd_cap_vo", v_o, 0);
      yumi_i = 1'($urandom_range(0, 1));
      tick();
      yumi_i = 1'b0;
      exp_w = beat_word(a, b);
      for (int w = 0; w <= d; w++) begin
        chk("rd_out_vo", v_o, 1);
        chk("rd_out_data", r_data_o, exp_w);
        chk("rd_out_no_rd_v", rf_rd_v_o, 0);
        chk("rd_out_done", done_o, 0);
        yumi_i = (w == d);
        tick();
      end
      yumi_i = 1'b0;
    end
    chk("rd_done", done_o, 1);
    chk("rd_done_vo", v_o, 0);
    chk("rd_done_rd_v", rf_rd_v_o, 0);
    tick();
    chk("rd_end_ready", ready_o, 1);
    chk("rd_end_done", done_o, 0);
    v_i = hold6_g;
  endtask

  task automatic check_illegal(input logic [2:0] op);
    chk("ill_done", done_o, 1);
    chk("ill_rd_v", rf_rd_v_o, 0);
    chk("ill_wr_v", rf_wr_v_o, 0);
    chk("ill_ready", ready_o, 0);
    chk("ill_lane_op", lane_op_o, op);
    tick();
    chk("ill_end_ready", ready_o, 1);
    chk("ill_end_done", done_o, 0);
    chk("ill_end_rd_v", rf_rd_v_o, 0);
    v_i = hold6_g;
  endtask

  task automatic run(input logic [2:0] op, input int a, input int b, input int c,
                     input logic [VDW-1:0] s, input int d1);
    issue(op, a, b, c, s);
    if (op <= 3'd3) check_exec(op, a, b, c, s);
    else if (op == 3'd4) check_read(a, d1);
    else check_illegal(op);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < ELS; a++)
      for (int e = 0; e < VLEN; e++) elem[a][e] = VDW'($urandom);
    reset_i = 1'b1; v_i = 1'b0; op_i = '0; yumi_i = 1'b0;
    addrA_i = '0; addrB_i = '0; addrC_i = '0; scalar_i = '0; rf_rd_data_i = '0;
    tick();
    tick();
    chk("rst_ready", ready_o, 1);
    chk("rst_rd_v", rf_rd_v_o, 0);
    chk("rst_wr_v", rf_wr_v_o, 0);
    chk("rst_vo", v_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_lane_op", lane_op_o, 0);
    chk("rst_lane_scalar", lane_scalar_o, 0);
    chk("rst_r_data", r_data_o, 0);
    chk("rst_rd_beat", rf_rd_beat_o, 0);
    reset_i = 1'b0;
    tick();

    // Basic VADD timeline.
    run(3'd0, 3, 4, 5, 8'h00, -1);
    // VSADD scalar latched despite later input changes (issue scrambles inputs).
    run(3'd3, 1, 2, 6, 8'h7F, -1);
    // VREAD with a three-cycle stall on beat 1.
    run(3'd4, 9, 0, 0, 8'h00, 3);
    // In-place VADD.
    run(3'd0, 7, 2, 7, 8'h11, -1);

    // Reset during EXEC beat 2 aborts the command.
    issue(3'd0, 10, 11, 12, 8'h22);
    tick();
    tick();
    chk("abort_pre_beat", rf_rd_beat_o, 2);
    v_i = 1'b0;
    reset_i = 1'b1;
    #1;
    chk("abort_rd_v", rf_rd_v_o, 0);
    chk("abort_wr_v", rf_wr_v_o, 0);
    chk("abort_ready", ready_o, 1);
    tick();
    reset_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_done", done_o, 0);
      chk("abort_no_rd", rf_rd_v_o, 0);
      chk("abort_no_wr", rf_wr_v_o, 0);
      chk("abort_ready_after", ready_o, 1);
    end

    // v_i held high with op 6 during a VADD: ignored until idle, then accepted.
    hold6_g = 1'b1;
    run(3'd0, 13, 14, 15, 8'h33, -1);
    hold6_g = 1'b0;
    tick();
    chk("op6_done", done_o, 1);
    chk("op6_rd_v", rf_rd_v_o, 0);
    chk("op6_wr_v", rf_wr_v_o, 0);
    chk("op6_lane_op", lane_op_o, 6);
    v_i = 1'b0;
    tick();
    chk("op6_end_ready", ready_o, 1);
    chk("op6_end_done", done_o, 0);

    // Random commands across all opcodes.
    for (int n = 0; n < 30; n++) begin
      run(3'($urandom_range(0, 7)), int'($urandom_range(0, ELS - 1)),
          int'($urandom_range(0, ELS - 1)), int'($urandom_range(0, ELS - 1)),
          VDW'($urandom), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
